cmd_phy_scheduler: RTL

//  Shares the CMD-line physical-layer controller between two requesters:
//  req0 = host register interface, req1 = data engine (auto CMD12/CMD13).

---
 rtl/cmd_phy_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cmd_phy_scheduler.sv
// cmd_phy_scheduler
//   Shares the CMD-line physical-layer controller between two requesters
//   (req0 = host register interface, req1 = data engine). Grants one
//   requester at a time with alternating priority, drives the strobe/ack
//   handshake with the physical layer, times out a missing response or ack,
//   aborts a hung exchange through phy_idle and hands the response back to
//   the granted requester.
//
// Ports
//   sd_clock, reset            CMD-domain clock, async active-high reset
//   req_valid[1:0]             per-requester request, held until req_done
//   req_cmd[2*CMD_W-1:0]       req1 frame in upper half, req0 in lower half
//   req_grant[1:0]             one-hot, requester currently served
//   req_done[1:0]              one-cycle completion pulse to the grantee
//   req_timeout                valid with req_done: no response / phy hang
//   resp_data[RESP_W-1:0]      response, valid with req_done, held until next
//   phy_command[CMD_W-1:0]     frame presented to the physical layer
//   phy_strobe / phy_ack       command request / response consumed
//   phy_idle / phy_no_resp     abort / response-timeout indication
//   phy_resp_strb, phy_ack_done, phy_response   physical-layer returns
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | no exchange in flight, waiting for any req_valid
// S_ARB       | pick a requester, latch its frame
// S_ISSUE     | phy_strobe high for this one cycle
// S_WAIT_RESP | counting toward response timeout, then toward abort
// S_ACK       | phy_ack high for this one cycle
// S_WAIT_ACK  | waiting for the physical layer to return the ack
// S_ABORT     | phy_idle high for this one cycle, response discarded
// S_DONE      | req_done / req_timeout pulse to the grantee

module cmd_phy_scheduler #(
  parameter int CMD_W       = 40,
  parameter int RESP_W      = 136,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  input  logic [2*CMD_W-1:0]   req_cmd,
  output logic [1:0]           req_grant,
  output logic [1:0]           req_done,
  output logic                 req_timeout,
  output logic [RESP_W-1:0]    resp_data,
  output logic [CMD_W-1:0]     phy_command,
  output logic                 phy_strobe,
  output logic                 phy_idle,
  output logic                 phy_no_resp,
  output logic                 phy_ack,
  input  logic                 phy_resp_strb,
  input  logic                 phy_ack_done,
  input  logic [RESP_W-1:0]    phy_response
);

  typedef enum logic [7:0] {
    S_IDLE      = 8'b0000_0001,
    S_ARB       = 8'b0000_0010,
    S_ISSUE     = 8'b0000_0100,
    S_WAIT_RESP = 8'b0000_1000,
    S_ACK       = 8'b0001_0000,
    S_WAIT_ACK  = 8'b0010_0000,
    S_ABORT     = 8'b0100_0000,
    S_DONE      = 8'b1000_0000
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ABORT_LAST = CNT_W'(2 * TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state;
  logic             last;
  logic             timeout_flag;
  logic [CNT_W-1:0] cnt;
  logic             pick1;

  // req1 wins when it is alone, or when both ask and req0 was served last.
  assign pick1 = req_valid[1] & (~req_valid[0] | ~last);

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      last         <= 1'b1;
      timeout_flag <= 1'b0;
      cnt          <= '0;
      req_grant    <= '0;
      req_done     <= '0;
      req_timeout  <= 1'b0;
      resp_data    <= '0;
      phy_command  <= '0;
      phy_strobe   <= 1'b0;
      phy_idle     <= 1'b0;
      phy_no_resp  <= 1'b0;
      phy_ack      <= 1'b0;
    end else begin
      // Every pulse output defaults low so each is high for one cycle only.
      phy_strobe  <= 1'b0;
      phy_idle    <= 1'b0;
      phy_no_resp <= 1'b0;
      phy_ack     <= 1'b0;
      req_done    <= '0;
      req_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) state <= S_ARB;
        end
        S_ARB: begin
          if (|req_valid) begin
            req_grant    <= pick1 ? 2'b10 : 2'b01;
            last         <= pick1;
            phy_command  <= pick1 ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
            timeout_flag <= 1'b0;
            phy_strobe   <= 1'b1;
            state        <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          // A late response is still accepted; the flag raised at the
          // first timeout is kept so the requester sees it was late.
          if (phy_resp_strb) begin
            resp_data <= phy_response;
            phy_ack   <= 1'b1;
            state     <= S_ACK;
          end else if (cnt == ABORT_LAST) begin
            phy_idle     <= 1'b1;
            timeout_flag <= 1'b1;
            resp_data    <= '0;
            state        <= S_ABORT;
          end else if (cnt == TO_LAST) begin
            phy_no_resp  <= 1'b1;
            timeout_flag <= 1'b1;
          end
        end
        S_ACK: begin
          cnt   <= '0;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          if (phy_ack_done) begin
            req_done    <= req_grant;
            req_timeout <= timeout_flag;
            state       <= S_DONE;
          end else if (cnt == TO_LAST) begin
            phy_idle     <= 1'b1;
            timeout_flag <= 1'b1;
            resp_data    <= '0;
            state        <= S_ABORT;
          end
        end
        S_ABORT: begin
          req_done    <= req_grant;
          req_timeout <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          req_grant <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
